// File: rtl/pc_gen.sv
// Fetch program-counter generator with trap/branch/increment selection, PC history and EPC capture.
// Latency: one cycle from request to pc_o; history and valid bits update on the same edge.
// Backpressure: stall_i holds PC and history (trap overrides); optional PC_COMPRESSED_EN adds 2-byte steps.
module pc_gen #(
    parameter int               XLEN        = 32,
    parameter int               HIST_DEPTH  = 2,
    parameter int               FLUSH_DEPTH = 2,
    parameter logic [XLEN-1:0]  RESET_VEC   = '0,
    parameter logic [XLEN-1:0]  TRAP_VEC    = XLEN'(32'h100)
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       stall_i,
    input  logic                       incr_pc_i,
    input  logic                       incr_size_i,
    input  logic                       load_arith_i,
    input  logic [XLEN-1:0]            arith_out_i,
    input  logic                       trap_i,
    output logic [XLEN-1:0]            pc_o,
    output logic [HIST_DEPTH*XLEN-1:0] pc_hist_o,
    output logic [HIST_DEPTH-1:0]      pc_hist_vld_o,
    output logic [XLEN-1:0]            epc_o,
    output logic                       misalign_o
);

    logic [XLEN-1:0]                  pc_q;
    logic [HIST_DEPTH-1:0][XLEN-1:0]  hist_q;
    logic [HIST_DEPTH-1:0]            vld_q;
    logic [XLEN-1:0]                  epc_q;
    logic                             misalign_q;

    logic [HIST_DEPTH-1:0][XLEN-1:0]  hist_shift;
    logic [HIST_DEPTH-1:0]            vld_shift;
    logic [HIST_DEPTH-1:0]            flush_keep;
    logic [XLEN-1:0]                  target_aligned;
    logic                             target_mis;
    logic [XLEN-1:0]                  step;

`ifdef PC_COMPRESSED_EN
    logic unused_target_bit0;
    assign unused_target_bit0 = arith_out_i[0];
    assign target_aligned     = {arith_out_i[XLEN-1:1], 1'b0};
    assign target_mis         = 1'b0;
    assign step               = incr_size_i ? XLEN'(2) : XLEN'(4);
`else
    // Bit 0 is dropped silently (jalr); bit 1 cannot be honoured without 16-bit fetch.
    logic [1:0] unused_inputs;
    assign unused_inputs  = {incr_size_i, arith_out_i[0]};
    assign target_aligned = {arith_out_i[XLEN-1:2], 2'b00};
    assign target_mis     = arith_out_i[1];
    assign step           = XLEN'(4);
`endif

    always_comb begin
        hist_shift    = hist_q;
        vld_shift     = vld_q;
        flush_keep    = '0;
        hist_shift[0] = pc_q;
        vld_shift[0]  = 1'b1;
        for (int k = 1; k < HIST_DEPTH; k++) begin
            hist_shift[k] = hist_q[k-1];
            vld_shift[k]  = vld_q[k-1];
        end
        // Youngest FLUSH_DEPTH stages hold wrong-path PCs after a redirect.
        for (int k = 0; k < HIST_DEPTH; k++) begin
            flush_keep[k] = (k >= FLUSH_DEPTH);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q       <= RESET_VEC;
            hist_q     <= '0;
            vld_q      <= '0;
            epc_q      <= '0;
            misalign_q <= 1'b0;
        end else if (trap_i) begin
            pc_q       <= TRAP_VEC;
            epc_q      <= hist_q[HIST_DEPTH-1];
            hist_q     <= hist_shift;
            vld_q      <= '0;
            misalign_q <= 1'b0;
        end else if (stall_i) begin
            misalign_q <= 1'b0;
        end else begin
            hist_q <= hist_shift;
            if (load_arith_i) begin
                pc_q       <= target_aligned;
                vld_q      <= vld_shift & flush_keep;
                misalign_q <= target_mis;
            end else begin
                vld_q      <= vld_shift;
                misalign_q <= 1'b0;
                if (incr_pc_i) begin
                    pc_q <= pc_q + step;
                end
            end
        end
    end

    assign pc_o          = pc_q;
    assign pc_hist_o     = hist_q;
    assign pc_hist_vld_o = vld_q;
    assign epc_o         = epc_q;
    assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes expected state, a monitor pops and compares after each update.
module tb_pc_gen;

`ifdef PC_COMPRESSED_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        incr_pc_i = 1'b0;
    logic        incr_size_i = 1'b0;
    logic        load_arith_i = 1'b0;
    logic [31:0] arith_out_i = '0;
    logic        trap_i = 1'b0;
    logic [31:0] pc_o;
    logic [63:0] pc_hist_o;
    logic [1:0]  pc_hist_vld_o;
    logic [31:0] epc_o;
    logic        misalign_o;

    pc_gen dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .stall_i       (stall_i),
        .incr_pc_i     (incr_pc_i),
        .incr_size_i   (incr_size_i),
        .load_arith_i  (load_arith_i),
        .arith_out_i   (arith_out_i),
        .trap_i        (trap_i),
        .pc_o          (pc_o),
        .pc_hist_o     (pc_hist_o),
        .pc_hist_vld_o (pc_hist_vld_o),
        .epc_o         (epc_o),
        .misalign_o    (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] h0;
        logic [31:0] h1;
        logic [1:0]  vld;
        logic [31:0] epc;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=0x%08h required=0x%08h", n, f, act, req);
        end
    endtask

    // Monitor: the DUT state changes on a clock edge or an asynchronous reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i or negedge rst_n_i);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.name, "pc",   pc_o,                 e.pc);
                chk(e.name, "h0",   pc_hist_o[31:0],      e.h0);
                chk(e.name, "h1",   pc_hist_o[63:32],     e.h1);
                chk(e.name, "vld",  {30'd0, pc_hist_vld_o}, {30'd0, e.vld});
                chk(e.name, "epc",  epc_o,                e.epc);
                chk(e.name, "mis",  {31'd0, misalign_o},  {31'd0, e.mis});
            end
        end
    end

    task automatic drive(input logic st, input logic inc, input logic sz,
                         input logic ld, input logic [31:0] tgt, input logic tr);
        @(negedge clk_i);
        stall_i      = st;
        incr_pc_i    = inc;
        incr_size_i  = sz;
        load_arith_i = ld;
        arith_out_i  = tgt;
        trap_i       = tr;
    endtask

    task automatic expect_st(input string n, input logic [31:0] pc, input logic [31:0] h0,
                             input logic [31:0] h1, input logic [1:0] vld,
                             input logic [31:0] epc, input logic mis);
        exp_t e;
        e.name = n; e.pc = pc; e.h0 = h0; e.h1 = h1; e.vld = vld; e.epc = epc; e.mis = mis;
        sb.push_back(e);
    endtask

    logic [31:0] a82, b87, incr2;

    initial begin
        a82   = CMP ? 32'h82 : 32'h80;
        b87   = CMP ? 32'h86 : 32'h84;
        incr2 = CMP ? 32'hA  : 32'hC;

        drive(0, 0, 0, 0, 0, 0);
        expect_st("reset", 32'h0, 0, 0, 2'b00, 0, 0);

        drive(0, 1, 0, 0, 0, 0); rst_n_i = 1'b1;
        expect_st("incr1", 32'h4, 32'h0, 32'h0, 2'b01, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        expect_st("incr2", 32'h8, 32'h4, 32'h0, 2'b11, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        expect_st("incr3", 32'hC, 32'h8, 32'h4, 2'b11, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        expect_st("incr4", 32'h10, 32'hC, 32'h8, 2'b11, 0, 0);

        drive(0, 0, 0, 1, 32'h80, 0);
        expect_st("branch", 32'h80, 32'h10, 32'hC, 2'b00, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        expect_st("post_br", 32'h84, 32'h80, 32'h10, 2'b01, 0, 0);

        drive(1, 1, 0, 1, 32'h200, 0);
        expect_st("stall1", 32'h84, 32'h80, 32'h10, 2'b01, 0, 0);
        drive(1, 1, 0, 1, 32'h200, 0);
        expect_st("stall2", 32'h84, 32'h80, 32'h10, 2'b01, 0, 0);

        drive(0, 0, 0, 1, 32'h20, 0);
        expect_st("br20", 32'h20, 32'h84, 32'h80, 2'b00, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        expect_st("inc24", 32'h24, 32'h20, 32'h84, 2'b01, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        expect_st("inc28", 32'h28, 32'h24, 32'h20, 2'b11, 0, 0);
        drive(1, 1, 0, 0, 0, 1);
        expect_st("trap_stall", 32'h100, 32'h28, 32'h24, 2'b00, 32'h20, 0);

        drive(0, 0, 0, 1, 32'h82, 0);
        expect_st("mis82", a82, 32'h100, 32'h28, 2'b00, 32'h20, !CMP);
        drive(0, 0, 0, 0, 0, 0);
        expect_st("hold", a82, a82, 32'h100, 2'b01, 32'h20, 0);
        drive(0, 0, 0, 1, 32'h87, 0);
        expect_st("mis87", b87, a82, a82, 2'b00, 32'h20, !CMP);
        drive(0, 0, 0, 0, 0, 1);
        expect_st("trap_clr", 32'h100, b87, a82, 2'b00, a82, 0);

        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        expect_st("br_top", 32'hFFFF_FFFC, 32'h100, b87, 2'b00, a82, 0);
        drive(0, 1, 0, 0, 0, 0);
        expect_st("wrap", 32'h0, 32'hFFFF_FFFC, 32'h100, 2'b01, a82, 0);
        drive(0, 0, 0, 1, 32'h41, 0);
        expect_st("bit0", 32'h40, 32'h0, 32'hFFFF_FFFC, 2'b00, a82, 0);
        drive(0, 0, 0, 0, 0, 0);
        expect_st("hold40", 32'h40, 32'h40, 32'h0, 2'b01, a82, 0);
        drive(0, 0, 0, 1, 32'h8, 0);
        expect_st("br8", 32'h8, 32'h40, 32'h40, 2'b00, a82, 0);
        drive(0, 1, 1, 0, 0, 0);
        expect_st("incr_sz", incr2, 32'h8, 32'h40, 2'b01, a82, 0);

        drive(0, 1, 0, 0, 0, 0);
        #2;
        expect_st("async_rst", 32'h0, 0, 0, 2'b00, 0, 0);
        rst_n_i = 1'b0;
        drive(0, 1, 0, 0, 0, 0); rst_n_i = 1'b1;
        expect_st("after_rst", 32'h4, 32'h0, 32'h0, 2'b01, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk_i);
        #3;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog elapsed=100000 required=done");
            $fatal(1, "watchdog");
        end
    end

endmodule
